sdram_port_arbiter: RTL and testbench

//  Round-robin arbiter sharing the single Avalon-MM SDRAM controller port between NREQ

---
 rtl/sdram_port_arbiter.sv | 191 +++++++++++++++++++
 tb/tb_sdram_port_arbiter.sv | 300 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sdram_port_arbiter.sv
// Round-robin arbiter sharing one Avalon-MM SDRAM controller port between NREQ masters,
// with a pending-read ID FIFO. Define SDRAM_ARB_FIXED_PRIO_EN for fixed priority (rq0 highest).
module sdram_port_arbiter #(
  parameter int unsigned NREQ     = 2,
  parameter int unsigned AW       = 25,
  parameter int unsigned DW       = 16,
  parameter int unsigned MAX_PEND = 8
) (
  input  logic                   clk_clk,
  input  logic                   reset_reset,
  input  logic [NREQ*AW-1:0]     rq_address,
  input  logic [NREQ-1:0]        rq_read,
  input  logic [NREQ-1:0]        rq_write,
  input  logic [NREQ*DW-1:0]     rq_writedata,
  input  logic [NREQ*(DW/8)-1:0] rq_byteenable,
  output logic [NREQ-1:0]        rq_waitrequest,
  output logic [DW-1:0]          rq_readdata,
  output logic [NREQ-1:0]        rq_readdatavalid,
  output logic [AW-1:0]          m_address,
  output logic                   m_read,
  output logic                   m_write,
  output logic [DW-1:0]          m_writedata,
  output logic [DW/8-1:0]        m_byteenable,
  input  logic                   m_waitrequest,
  input  logic [DW-1:0]          m_readdata,
  input  logic                   m_readdatavalid,
  output logic [1:0]             grant_id,
  output logic                   err_underflow
);

  localparam int unsigned PW = (MAX_PEND > 1) ? $clog2(MAX_PEND) : 1;
  localparam int unsigned BW = DW / 8;

  typedef enum logic [0:0] {StIdle, StGrant} state_e;

  state_e        r_state;
  logic [1:0]    r_winner;
  logic [1:0]    r_rr_ptr;
  logic [1:0]    r_fifo [MAX_PEND];
  logic [PW-1:0] r_wr_ptr;
  logic [PW-1:0] r_rd_ptr;
  logic [PW:0]   r_count;
  logic          r_err;

  logic              w_fifo_full;
  logic              w_fifo_empty;
  logic [NREQ-1:0]   w_eligible;
  logic              w_any;
  logic [1:0]        w_pick;
  int unsigned       w_idx;
  logic              w_sel_read;
  logic              w_sel_write;
  logic [AW-1:0]     w_sel_addr;
  logic [DW-1:0]     w_sel_wdata;
  logic [BW-1:0]     w_sel_be;
  logic              w_accept;
  logic              w_push;
  logic              w_pop;

  assign w_fifo_full  = (r_count == (PW+1)'(MAX_PEND));
  assign w_fifo_empty = (r_count == '0);
  assign w_eligible   = rq_write | (rq_read & {NREQ{~w_fifo_full}});

  // First eligible requester searching upward from the rr pointer, wrapping at NREQ.
  always_comb begin
    w_any  = 1'b0;
    w_pick = r_rr_ptr;
    w_idx  = 0;
    for (int unsigned k = 0; k < NREQ; k++) begin
      w_idx = {30'd0, r_rr_ptr} + k;
      if (w_idx >= NREQ) w_idx = w_idx - NREQ;
      for (int unsigned i = 0; i < NREQ; i++) begin
        if (!w_any && (w_idx == i) && w_eligible[i]) begin
          w_any  = 1'b1;
          w_pick = 2'(i);
        end
      end
    end
  end

  always_comb begin
    w_sel_read  = 1'b0;
    w_sel_write = 1'b0;
    w_sel_addr  = '0;
    w_sel_wdata = '0;
    w_sel_be    = '0;
    for (int unsigned i = 0; i < NREQ; i++) begin
      if (r_winner == 2'(i)) begin
        w_sel_read  = rq_read[i];
        w_sel_write = rq_write[i];
        w_sel_addr  = rq_address[i*AW +: AW];
        w_sel_wdata = rq_writedata[i*DW +: DW];
        w_sel_be    = rq_byteenable[i*BW +: BW];
      end
    end
  end

  // Write wins when a master raises both read and write.
  always_comb begin
    m_read       = 1'b0;
    m_write      = 1'b0;
    m_address    = '0;
    m_writedata  = '0;
    m_byteenable = '0;
    if (r_state == StGrant) begin
      m_read       = w_sel_read & ~w_sel_write;
      m_write      = w_sel_write;
      m_address    = w_sel_addr;
      m_writedata  = w_sel_wdata;
      m_byteenable = w_sel_be;
    end
  end

  always_comb begin
    rq_waitrequest = '1;
    for (int unsigned i = 0; i < NREQ; i++) begin
      if ((r_state == StGrant) && (r_winner == 2'(i))) rq_waitrequest[i] = m_waitrequest;
    end
  end

  assign w_accept = (m_read | m_write) & ~m_waitrequest;
  assign w_pop    = m_readdatavalid & ~w_fifo_empty;
  assign w_push   = w_accept & m_read & (~w_fifo_full | w_pop);

  assign rq_readdata = m_readdata;

  always_comb begin
    rq_readdatavalid = '0;
    for (int unsigned i = 0; i < NREQ; i++) begin
      if (w_pop && (r_fifo[r_rd_ptr] == 2'(i))) rq_readdatavalid[i] = 1'b1;
    end
  end

  assign grant_id      = r_winner;
  assign err_underflow = r_err;

  always_ff @(posedge clk_clk or posedge reset_reset) begin
    if (reset_reset) begin
      r_state  <= StIdle;
      r_winner <= '0;
      r_rr_ptr <= '0;
    end else begin
      unique case (r_state)
        StIdle: begin
          if (w_any) begin
            r_winner <= w_pick;
            r_state  <= StGrant;
          end
        end
        StGrant: begin
          if (w_accept) begin
`ifdef SDRAM_ARB_FIXED_PRIO_EN
            r_rr_ptr <= '0;
`else
            if (r_winner == 2'(NREQ-1)) r_rr_ptr <= '0;
            else                        r_rr_ptr <= r_winner + 2'd1;
`endif
            r_state <= StIdle;
          end else if (!w_sel_read && !w_sel_write) begin
            // Master withdrew its request without a transfer: release the port.
            r_state <= StIdle;
          end
        end
        default: r_state <= StIdle;
      endcase
    end
  end

  always_ff @(posedge clk_clk or posedge reset_reset) begin
    if (reset_reset) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
      r_err    <= 1'b0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
      if (m_readdatavalid && w_fifo_empty) r_err <= 1'b1;
    end
  end

  always_ff @(posedge clk_clk) begin
    if (w_push) r_fifo[r_wr_ptr] <= r_winner;
  end

endmodule

// File: tb/tb_sdram_port_arbiter.sv
// Directed self-checking bench for sdram_port_arbiter (NREQ=2, MAX_PEND=8).
module tb_sdram_port_arbiter;

  localparam int NREQ = 2;
  localparam int AW   = 25;
  localparam int DW   = 16;

`ifdef SDRAM_ARB_FIXED_PRIO_EN
  localparam bit FIXED = 1'b1;
`else
  localparam bit FIXED = 1'b0;
`endif

  logic                   clk = 1'b0;
  logic                   rst;
  logic [NREQ*AW-1:0]     rq_address;
  logic [NREQ-1:0]        rq_read;
  logic [NREQ-1:0]        rq_write;
  logic [NREQ*DW-1:0]     rq_writedata;
  logic [NREQ*(DW/8)-1:0] rq_byteenable;
  logic [NREQ-1:0]        rq_waitrequest;
  logic [DW-1:0]          rq_readdata;
  logic [NREQ-1:0]        rq_readdatavalid;
  logic [AW-1:0]          m_address;
  logic                   m_read;
  logic                   m_write;
  logic [DW-1:0]          m_writedata;
  logic [DW/8-1:0]        m_byteenable;
  logic                   m_waitrequest;
  logic [DW-1:0]          m_readdata;
  logic                   m_readdatavalid;
  logic [1:0]             grant_id;
  logic                   err_underflow;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  sdram_port_arbiter #(.NREQ(NREQ), .AW(AW), .DW(DW), .MAX_PEND(8)) dut (
    .clk_clk          (clk),
    .reset_reset      (rst),
    .rq_address       (rq_address),
    .rq_read          (rq_read),
    .rq_write         (rq_write),
    .rq_writedata     (rq_writedata),
    .rq_byteenable    (rq_byteenable),
    .rq_waitrequest   (rq_waitrequest),
    .rq_readdata      (rq_readdata),
    .rq_readdatavalid (rq_readdatavalid),
    .m_address        (m_address),
    .m_read           (m_read),
    .m_write          (m_write),
    .m_writedata      (m_writedata),
    .m_byteenable     (m_byteenable),
    .m_waitrequest    (m_waitrequest),
    .m_readdata       (m_readdata),
    .m_readdatavalid  (m_readdatavalid),
    .grant_id         (grant_id),
    .err_underflow    (err_underflow)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    rq_address      = '0;
    rq_read         = '0;
    rq_write        = '0;
    rq_writedata    = '0;
    rq_byteenable   = '0;
    m_waitrequest   = 1'b1;
    m_readdata      = '0;
    m_readdatavalid = 1'b0;
  endtask

  task automatic do_reset();
    idle_inputs();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    idle_inputs();
    rst = 1'b1;
    #2;
    total++; if (m_read !== 1'b0) begin bad++; $display("FAIL rst_m_read got %b want 0", m_read); end
    total++; if (m_write !== 1'b0) begin bad++; $display("FAIL rst_m_write got %b want 0", m_write); end
    total++; if (rq_waitrequest !== 2'b11) begin
      bad++; $display("FAIL rst_waitreq got %b want 11", rq_waitrequest);
    end
    total++; if (rq_readdatavalid !== 2'b00) begin
      bad++; $display("FAIL rst_rdv got %b want 00", rq_readdatavalid);
    end
    total++; if (grant_id !== 2'd0) begin bad++; $display("FAIL rst_grant got %0d want 0", grant_id); end
    total++; if (err_underflow !== 1'b0) begin
      bad++; $display("FAIL rst_err got %b want 0", err_underflow);
    end
    tick();
    rst = 1'b0;
    // Put rq1 in GRANT, then reset mid-grant.
    rq_read = 2'b10;
    tick();
    total++; if (grant_id !== 2'd1 || m_read !== 1'b1) begin
      bad++; $display("FAIL pre_rst_grant got id=%0d rd=%b want id=1 rd=1", grant_id, m_read);
    end
    #1 rst = 1'b1;
    #1;
    total++; if (m_read !== 1'b0 || rq_waitrequest !== 2'b11 || grant_id !== 2'd0) begin
      bad++;
      $display("FAIL mid_rst got rd=%b wr=%b id=%0d want rd=0 wr=11 id=0",
               m_read, rq_waitrequest, grant_id);
    end
    idle_inputs();
    tick();
    rst = 1'b0;
  endtask

  task automatic test_single_write();
    do_reset();
    rq_address[AW-1:0]    = 25'h000100;
    rq_writedata[DW-1:0]  = 16'hBEEF;
    rq_byteenable[1:0]    = 2'b11;
    rq_write              = 2'b01;
    tick();
    total++; if (m_write !== 1'b1 || m_address !== 25'h000100 || m_writedata !== 16'hBEEF ||
                 m_byteenable !== 2'b11) begin
      bad++;
      $display("FAIL wr_fields got wr=%b a=%h d=%h be=%b want 1 000100 beef 11",
               m_write, m_address, m_writedata, m_byteenable);
    end
    total++; if (rq_waitrequest !== 2'b11) begin
      bad++; $display("FAIL wr_wait1 got %b want 11", rq_waitrequest);
    end
    tick();
    total++; if (rq_waitrequest !== 2'b11) begin
      bad++; $display("FAIL wr_wait2 got %b want 11", rq_waitrequest);
    end
    m_waitrequest = 1'b0;
    #1;
    total++; if (rq_waitrequest !== 2'b10) begin
      bad++; $display("FAIL wr_accept_wait got %b want 10", rq_waitrequest);
    end
    tick();
    rq_write = 2'b00;
    #1;
    total++; if (m_write !== 1'b0 || rq_waitrequest !== 2'b11) begin
      bad++; $display("FAIL wr_after got wr=%b wait=%b want 0 11", m_write, rq_waitrequest);
    end
  endtask

  task automatic test_alternate();
    logic [1:0] exp_id;
    logic [1:0] exp_rdv;
    do_reset();
    m_waitrequest = 1'b0;
    rq_read = 2'b11;
    for (int g = 0; g < 4; g++) begin
      tick();
      exp_id = FIXED ? 2'd0 : 2'(g % 2);
      total++; if (grant_id !== exp_id || m_read !== 1'b1) begin
        bad++; $display("FAIL alt_grant%0d got id=%0d rd=%b want id=%0d rd=1",
                        g, grant_id, m_read, exp_id);
      end
      total++; if (rq_waitrequest !== ~(2'b01 << exp_id)) begin
        bad++; $display("FAIL alt_wait%0d got %b want %b", g, rq_waitrequest, ~(2'b01 << exp_id));
      end
      tick();
    end
    rq_read = 2'b00;
    for (int n = 0; n < 4; n++) begin
      m_readdatavalid = 1'b1;
      m_readdata      = 16'h1000 + 16'(n);
      #1;
      exp_rdv = (FIXED || (n % 2 == 0)) ? 2'b01 : 2'b10;
      total++; if (rq_readdatavalid !== exp_rdv || rq_readdata !== 16'h1000 + 16'(n)) begin
        bad++; $display("FAIL alt_ret%0d got v=%b d=%h want v=%b d=%h",
                        n, rq_readdatavalid, rq_readdata, exp_rdv, 16'h1000 + 16'(n));
      end
      tick();
    end
    m_readdatavalid = 1'b0;
  endtask

  task automatic test_fifo_full();
    do_reset();
    m_waitrequest = 1'b0;
    rq_read = 2'b01;
    for (int g = 0; g < 8; g++) begin
      tick();
      total++; if (m_read !== 1'b1 || grant_id !== 2'd0) begin
        bad++; $display("FAIL full_fill%0d got rd=%b id=%0d want 1 0", g, m_read, grant_id);
      end
      tick();
    end
    tick();
    tick();
    total++; if (m_read !== 1'b0 || rq_waitrequest !== 2'b11) begin
      bad++; $display("FAIL full_stall got rd=%b wait=%b want 0 11", m_read, rq_waitrequest);
    end
    rq_write = 2'b10;
    rq_address[2*AW-1:AW] = 25'h0ABCDE;
    tick();
    total++; if (m_write !== 1'b1 || grant_id !== 2'd1 || m_address !== 25'h0ABCDE) begin
      bad++; $display("FAIL full_write got wr=%b id=%0d a=%h want 1 1 0abcde",
                      m_write, grant_id, m_address);
    end
    tick();
    rq_write = 2'b00;
    m_readdatavalid = 1'b1;
    #1;
    total++; if (rq_readdatavalid !== 2'b01) begin
      bad++; $display("FAIL full_pop got %b want 01", rq_readdatavalid);
    end
    tick();
    m_readdatavalid = 1'b0;
    tick();
    total++; if (m_read !== 1'b1 || grant_id !== 2'd0) begin
      bad++; $display("FAIL full_ninth got rd=%b id=%0d want 1 0", m_read, grant_id);
    end
    tick();
    rq_read = 2'b00;
  endtask

  task automatic test_push_pop_underflow();
    logic [1:0] exp_rdv;
    do_reset();
    m_waitrequest = 1'b0;
    rq_read = 2'b01;
    for (int g = 0; g < 7; g++) begin
      tick();
      tick();
    end
    rq_read = 2'b10;
    tick();
    // rq1 accept coincides with a pop of rq0's oldest read.
    m_readdatavalid = 1'b1;
    #1;
    total++; if (m_read !== 1'b1 || grant_id !== 2'd1 || rq_readdatavalid !== 2'b01) begin
      bad++; $display("FAIL pp_same got rd=%b id=%0d v=%b want 1 1 01",
                      m_read, grant_id, rq_readdatavalid);
    end
    tick();
    m_readdatavalid = 1'b0;
    tick();
    total++; if (m_read !== 1'b1 || grant_id !== 2'd1) begin
      bad++; $display("FAIL pp_eighth got rd=%b id=%0d want 1 1", m_read, grant_id);
    end
    tick();
    tick();
    total++; if (m_read !== 1'b0 || rq_waitrequest !== 2'b11) begin
      bad++; $display("FAIL pp_full got rd=%b wait=%b want 0 11", m_read, rq_waitrequest);
    end
    rq_read = 2'b00;
    tick();
    for (int n = 0; n < 8; n++) begin
      m_readdatavalid = 1'b1;
      #1;
      exp_rdv = (n < 6) ? 2'b01 : 2'b10;
      total++; if (rq_readdatavalid !== exp_rdv) begin
        bad++; $display("FAIL pp_drain%0d got %b want %b", n, rq_readdatavalid, exp_rdv);
      end
      tick();
    end
    total++; if (err_underflow !== 1'b0) begin
      bad++; $display("FAIL pp_no_err got %b want 0", err_underflow);
    end
    #1;
    total++; if (rq_readdatavalid !== 2'b00) begin
      bad++; $display("FAIL uf_rdv got %b want 00", rq_readdatavalid);
    end
    tick();
    m_readdatavalid = 1'b0;
    tick();
    total++; if (err_underflow !== 1'b1) begin
      bad++; $display("FAIL uf_err got %b want 1", err_underflow);
    end
    do_reset();
    total++; if (err_underflow !== 1'b0) begin
      bad++; $display("FAIL uf_clear got %b want 0", err_underflow);
    end
  endtask

  initial begin
    rst = 1'b1;
    idle_inputs();
    test_reset();
    test_single_write();
    test_alternate();
    test_fifo_full();
    test_push_pop_underflow();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
